// File: rtl/move_input_conditioner.sv
// Turns four raw pushbuttons into clean single-cycle move pulses:
// polarity fix, two-flop sync, debounce, edge detect, one-move-per-press arbitration.
module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_up,
    input  logic raw_down,
    input  logic raw_left,
    input  logic raw_right,
    input  logic game_over,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic any_move,
    output logic locked
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ARMED  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right.
    logic [3:0]    w_raw;
    logic [3:0]    r_s1;
    logic [3:0]    r_s2;
    logic [3:0]    r_db;
    logic [3:0]    r_dbPrev;
    logic [CW-1:0] r_cnt [4];
    logic [3:0]    w_press;
    logic [3:0]    w_pulseNext;
    logic [3:0]    r_pulse;
    logic          r_anyMove;
    state_t        r_state;
    state_t        w_nextState;

    assign w_raw = {raw_up, raw_down, raw_left, raw_right} ^ {4{ACTIVE_LOW}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Any cycle where the synchronized level agrees with db restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db     <= '0;
            r_dbPrev <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_dbPrev <= r_db;
            for (int i = 0; i < 4; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_db[i]  <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_press = r_db & ~r_dbPrev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARMED;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ARMED: begin
                if (game_over || (w_press != 4'b0000)) begin
                    w_nextState = LOCKED;
                end
            end
            LOCKED: begin
                if ((r_db == 4'b0000) && !game_over) begin
                    w_nextState = ARMED;
                end
            end
            default: w_nextState = ARMED;
        endcase
    end

    // game_over takes precedence over a press evaluated in the same cycle.
    always_comb begin
        w_pulseNext = 4'b0000;
        if ((r_state == ARMED) && !game_over) begin
            if (w_press[3]) begin
                w_pulseNext = 4'b1000;
            end else if (w_press[2]) begin
                w_pulseNext = 4'b0100;
            end else if (w_press[1]) begin
                w_pulseNext = 4'b0010;
            end else if (w_press[0]) begin
                w_pulseNext = 4'b0001;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse   <= '0;
            r_anyMove <= 1'b0;
        end else begin
            r_pulse   <= w_pulseNext;
            r_anyMove <= |w_pulseNext;
        end
    end

    assign up       = r_pulse[3];
    assign down     = r_pulse[2];
    assign left     = r_pulse[1];
    assign right    = r_pulse[0];
    assign any_move = r_anyMove;
    assign locked   = (r_state == LOCKED);

endmodule

// File: tb/tb_move_input_conditioner.sv
// Scoreboard bench for move_input_conditioner with a short debounce window.
// Stimulus queues expected pulses; a negedge monitor pops and compares them.
module tb_move_input_conditioner;

    localparam int DB = 4;

    typedef struct {
        logic [3:0] dirs;
        int         cycle;
    } expect_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rawUp = 1'b1;
    logic rawDown = 1'b1;
    logic rawLeft = 1'b1;
    logic rawRight = 1'b1;
    logic gameOver = 1'b0;
    logic up, down, left, right, anyMove, locked;

    int cycleCount = 0;
    int checks = 0;
    int errors = 0;
    expect_t expQ[$];
    expect_t monExp;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_up(rawUp),
        .raw_down(rawDown),
        .raw_left(rawLeft),
        .raw_right(rawRight),
        .game_over(gameOver),
        .up(up),
        .down(down),
        .left(left),
        .right(right),
        .any_move(anyMove),
        .locked(locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Buttons given as a pressed mask {up,down,left,right}; raw lines are active-low.
    task automatic applyStimulus(logic [3:0] pressed);
        @(posedge clk);
        #1;
        {rawUp, rawDown, rawLeft, rawRight} = ~pressed;
    endtask

    task automatic waitNeg(int target);
        do @(negedge clk); while (cycleCount < target);
    endtask

    task automatic expectPulse(logic [3:0] dirs, int cycle);
        expect_t e;
        e.dirs  = dirs;
        e.cycle = cycle;
        expQ.push_back(e);
    endtask

    task automatic pressExpect(logic [3:0] pressed, logic [3:0] dirs, int hold);
        int e0;
        applyStimulus(pressed);
        e0 = cycleCount;
        expectPulse(dirs, e0 + DB + 3);
        waitNeg(e0 + hold - 1);
    endtask

    task automatic releaseAll(string tag);
        int e1;
        applyStimulus(4'b0000);
        e1 = cycleCount;
        waitNeg(e1 + DB + 2);
        checkOutput({tag, "_locked_hold"}, int'(locked), 1);
        waitNeg(e1 + DB + 3);
        checkOutput({tag, "_locked_clear"}, int'(locked), 0);
    endtask

    // Every cycle with any pulse output high must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && (up || down || left || right || anyMove)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got udlr=%b any=%b, expected none (cycle %0d)",
                         {up, down, left, right}, anyMove, cycleCount);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("pulse_dirs", int'({up, down, left, right}), int'(monExp.dirs));
                checkOutput("pulse_any_move", int'(anyMove), 1);
                checkOutput("pulse_cycle", cycleCount, monExp.cycle);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0, t, g;

        // Reset values, then a held up press from reset release
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_pulses", int'({up, down, left, right, anyMove}), 0);
        checkOutput("reset_locked", int'(locked), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rawUp = 1'b0;
        e0 = cycleCount;
        expectPulse(4'b1000, e0 + 7);
        waitNeg(e0 + 6);
        checkOutput("s1_locked_before", int'(locked), 0);
        waitNeg(e0 + 8);
        checkOutput("s1_locked_after", int'(locked), 1);
        waitNeg(e0 + 11);
        releaseAll("s1");

        // Bounce rejection on left, then a clean left press
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0010);
            t = cycleCount;
            waitNeg(t + 1);
            checkOutput("s2_bounce_locked", int'(locked), 0);
            applyStimulus(4'b0000);
            t = cycleCount;
            waitNeg(t + 1);
        end
        t = cycleCount;
        waitNeg(t + 8);
        checkOutput("s2_quiet_locked", int'(locked), 0);
        pressExpect(4'b0010, 4'b0010, 20);
        releaseAll("s2");

        // Simultaneous down+right: down wins; later right alone
        pressExpect(4'b0101, 4'b0100, 12);
        releaseAll("s3a");
        t = cycleCount;
        waitNeg(t + 3);
        pressExpect(4'b0001, 4'b0001, 12);
        releaseAll("s3b");

        // Long up hold with an overlapping left press
        applyStimulus(4'b1000);
        e0 = cycleCount;
        expectPulse(4'b1000, e0 + 7);
        waitNeg(e0 + 19);
        applyStimulus(4'b1010);
        waitNeg(e0 + 40);
        checkOutput("s4_locked_overlap", int'(locked), 1);
        waitNeg(e0 + 49);
        releaseAll("s4");

        // game_over suppresses all moves
        @(posedge clk);
        #1;
        gameOver = 1'b1;
        g = cycleCount;
        waitNeg(g + 1);
        checkOutput("s5_locked_enter", int'(locked), 1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(4'(1 << b));
            t = cycleCount;
            waitNeg(t + 9);
            checkOutput("s5_locked_pressed", int'(locked), 1);
            applyStimulus(4'b0000);
            t = cycleCount;
            waitNeg(t + 9);
            checkOutput("s5_locked_released", int'(locked), 1);
        end
        @(posedge clk);
        #1;
        gameOver = 1'b0;
        g = cycleCount;
        waitNeg(g);
        checkOutput("s5_locked_drop_same", int'(locked), 1);
        waitNeg(g + 1);
        checkOutput("s5_locked_drop_next", int'(locked), 0);
        pressExpect(4'b0100, 4'b0100, 10);
        releaseAll("s5");

        // Reset mid-debounce, then reset while locked with the button still held
        applyStimulus(4'b1000);
        e0 = cycleCount;
        waitNeg(e0 + 3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("s6_reset1_pulses", int'({up, down, left, right, anyMove}), 0);
        checkOutput("s6_reset1_locked", int'(locked), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        t = cycleCount;
        expectPulse(4'b1000, t + 7);
        waitNeg(t + 9);
        checkOutput("s6_locked_after_pulse", int'(locked), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("s6_reset2_locked", int'(locked), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        t = cycleCount;
        expectPulse(4'b1000, t + 7);
        waitNeg(t + 9);
        releaseAll("s6");

        t = cycleCount;
        waitNeg(t + 2);
        checkOutput("queue_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
